vx_pipe_arbiter: RTL
====================

Name: vx_pipe_arbiter

Overview:
- Shares one registered elastic pipeline stage among NUM_REQS requesters.
- Round-robin arbitration with optional packet locking: a requester holds the grant from first beat to `last` beat.
- Output stage is a single full-throughput register slice: data_out, valid_out and sel_out are registered; ready couples combinationally.
- Sits in front of shared downstream resources (memory ports, shared functional-unit issue paths).

Parameters:
- NUM_REQS, 4, number of requesters (>=1).
- DATAW, 32, payload width per requester.
- LOCK_EN, 1, 1 = hold grant until a beat with last_in=1 is accepted; 0 = re-arbitrate every beat.
- SELW, $clog2(NUM_REQS) min 1, width of sel_out.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- valid_in  in  NUM_REQS  per-requester valid.
- data_in  in  NUM_REQS*DATAW  per-requester payload; requester i at [i*DATAW +: DATAW].
- last_in  in  NUM_REQS  end-of-packet marker per requester; ignored when LOCK_EN=0.
- ready_in  out  NUM_REQS  per-requester ready; one-hot or zero.
- valid_out  out  1  registered output valid.
- data_out  out  DATAW  registered payload.
- last_out  out  1  registered last marker.
- sel_out  out  SELW  registered index of the source requester.
- ready_out  in  1  downstream ready.

Behaviour:
- Reset values, forced asynchronously while reset=0:
  - valid_out=0, data_out=0, last_out=0, sel_out=0.
  - rr_ptr=0, state=IDLE, owner=0.
- Stage enable: en = ready_out | ~valid_out.
- Grant (combinational):
  - IDLE: grant goes to the first i with valid_in[i]=1, scanning i=rr_ptr, rr_ptr+1, ... modulo NUM_REQS.
  - LOCKED: grant = owner only if valid_in[owner]=1, else none.
  - Grant depends only on valid_in, state, rr_ptr and owner. It never depends on ready_out, so there is no valid-on-ready loop.
- ready_in[g] = en & grant valid; all other bits are 0.
- Accept = valid_in[g] & ready_in[g].
- Output register update:
  - On en: valid_out <= any grant; data_out/last_out/sel_out <= the granted requester's values.
  - When en=1 and there is no grant, valid_out <= 0; data_out/last_out/sel_out retain their value.
  - When en=0, all outputs hold.
- Latency: 1 cycle from accept to valid_out. Throughput: 1 beat/cycle under continuous ready_out.
- State machine (LOCK_EN=1):
  - IDLE -> LOCKED on accept with last_in[g]=0; owner <= g.
  - LOCKED -> LOCKED on accept with last=0, or on no accept.
  - LOCKED -> IDLE on accept with last=1; rr_ptr <= (owner+1) mod NUM_REQS.
  - IDLE, accept with last=1: stay IDLE; rr_ptr <= (g+1) mod NUM_REQS.
- LOCK_EN=0: state stays IDLE; every accept sets rr_ptr <= (g+1) mod NUM_REQS; last_in is still forwarded to last_out.
- rr_ptr advances only on accept, never on idle cycles. Wrap: NUM_REQS-1 -> 0.
- Owner drops valid mid-packet: lock is held, no other requester is granted, and a bubble is emitted.
- ready_out=0 with a full stage: ready_in is all 0 and the grant is not consumed; pointer and state hold.
- NUM_REQS=1: grant is always 0 when valid; sel_out is constant 0; ports behave as a plain pipe stage.
- Reset mid-packet clears the lock and discards the staged beat.

Decomposition:
- Package vx_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  - function rr_next(ptr, n) for modulo increment.
- One sub-module, vx_rr_picker:
  - Combinational; parameter NUM_REQS.
  - Inputs: requests, rr_ptr. Outputs: grant_valid, grant_idx, grant_onehot.
  - Reusable by other arbiters.
- The output register is inlined: the async active-low reset differs from existing synchronous-reset pipe registers.

Test Plan:
- Reset: hold reset=0 with valid_in=4'b1111 -> valid_out=0, ready_in=0, sel_out=0. Release: first beat comes from req0 and appears the next cycle.
- Fairness, LOCK_EN=0: valid_in=4'b1111 every beat with last=1, ready_out=1 -> sel_out sequence 0,1,2,3,0,1; one beat per cycle, no bubbles.
- Locking: req2 sends 3 beats (last=0,0,1) while req0 and req1 are continuously valid -> sel_out=2,2,2, then 3 if req3 is valid, else 0. rr_ptr=3 after the packet.
- Backpressure: ready_out=0 for 4 cycles with the stage full -> data_out stable, ready_in=0, rr_ptr unchanged. On ready_out=1 the staged beat drains and the next beat is accepted in the same cycle.
- Owner gap: req1 is locked after a last=0 beat and drops valid for 2 cycles while req3 is valid -> two bubbles (valid_out=0), req3 not granted; req1 resumes and completes with last=1 -> req3 is granted next.
- Async reset mid-packet: assert reset=0 between clock edges while LOCKED -> valid_out=0 immediately. After release, arbitration starts at req0 in IDLE.

Source files
------------

// File: rtl/vx_arb_pkg.sv
// vx_arb_pkg: shared arbiter state encoding and round-robin pointer helper
package vx_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  function automatic logic [31:0] rr_next(input logic [31:0] ptr, input logic [31:0] n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction
endpackage

// File: rtl/vx_rr_picker.sv
// vx_rr_picker: combinational round-robin search starting at rr_ptr
module vx_rr_picker #(
  parameter int NUM_REQS = 4,
  parameter int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] requests,
  input  logic [SELW-1:0]     rr_ptr,
  output logic                grant_valid,
  output logic [SELW-1:0]     grant_idx,
  output logic [NUM_REQS-1:0] grant_onehot
);
  function automatic logic [SELW-1:0] idx_at(input logic [SELW-1:0] ptr, input int k);
    logic [31:0] s;
    s = 32'(ptr) + 32'(k);
    return SELW'((s >= 32'(NUM_REQS)) ? s - 32'(NUM_REQS) : s);
  endfunction
  // scan farthest offset first so the nearest requester at or after rr_ptr wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (requests[idx_at(rr_ptr, k)]) begin
        grant_valid = 1'b1;
        grant_idx = idx_at(rr_ptr, k);
      end
    end
  end
  assign grant_onehot = NUM_REQS'(grant_valid) << grant_idx;
endmodule

// File: rtl/vx_pipe_arbiter.sv
// vx_pipe_arbiter: round-robin arbiter with packet locking feeding one registered elastic stage
module vx_pipe_arbiter
  import vx_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 32,
  parameter int LOCK_EN = 1,
  parameter int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       last_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      last_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out
);
  arb_state_t state;
  logic [SELW-1:0] owner, rr_ptr, pick_idx, grant_idx;
  logic [NUM_REQS-1:0] pick_onehot;
  logic pick_valid, grant_valid, locked, en, accept, grant_last;

  vx_rr_picker #(.NUM_REQS(NUM_REQS), .SELW(SELW)) picker (
    .requests    (valid_in),
    .rr_ptr      (rr_ptr),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx),
    .grant_onehot(pick_onehot)
  );

  assign locked = (state == ARB_LOCKED);
  assign grant_valid = locked ? valid_in[owner] : pick_valid;
  assign grant_idx = locked ? owner : pick_idx;
  assign grant_last = last_in[grant_idx];
  assign en = ready_out | ~valid_out;
  assign accept = en & grant_valid;
  // ready is withheld during reset so no requester believes a beat was taken
  assign ready_in = (!reset || !en) ? '0 : locked ? (NUM_REQS'(valid_in[owner]) << owner) : pick_onehot;

  // lock/pointer bookkeeping and the output register slice, both advanced only by an accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      owner <= '0;
      rr_ptr <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      last_out <= 1'b0;
      sel_out <= '0;
    end else if (en) begin
      valid_out <= grant_valid;
      if (grant_valid) begin
        data_out <= data_in[grant_idx*DATAW +: DATAW];
        last_out <= grant_last;
        sel_out <= grant_idx;
        if (LOCK_EN != 0 && !grant_last) begin
          state <= ARB_LOCKED;
          owner <= grant_idx;
        end else begin
          state <= ARB_IDLE;
          rr_ptr <= SELW'(rr_next(32'(grant_idx), NUM_REQS));
        end
      end
    end
  end
endmodule
